uart_tx_phy: RTL and testbench

Transmit physical layer of the UART peripheral. Pops bytes from the TX FIFO and serializes them onto `txd`: start bit, 8 data bits LSB first, then 1 or 2 stop bits. It sits between the TX FIFO and the pin, and takes `txen`, `nstop` and `div` directly from the UART register bank. Bit period is `div + 1` clock cycles, so baud = clock frequency / (`div` + 1).

---
 rtl/uart_tx_phy.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_phy.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_phy.sv
// UART transmit PHY: pops bytes from a FWFT TX FIFO and serializes them as start, 8 data LSB-first, [parity], 1-2 stop.
// Latency: pop to start-bit edge 1 cycle; bit period div+1 cycles; gapless back-to-back frames.
// Backpressure: pops only when txen & !tx_fifo_empty in IDLE or the last stop cycle; optional parity via UART_TX_PARITY_EN.
module uart_tx_phy #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 txen,
   input  logic                 nstop,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic                 tx_fifo_empty,
   input  logic [7:0]           tx_fifo_rd_data,
   output logic                 tx_fifo_rd_en,
   output logic                 txd,
   output logic                 busy,
   output logic                 frame_done
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
`endif

   localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   logic [2:0]           state_q,    state_d;
   logic [DIV_WIDTH-1:0] cnt_q,      cnt_d;
   logic [DIV_WIDTH-1:0] div_q,      div_d;
   logic                 nstop_q,    nstop_d;
   logic [7:0]           shift_q,    shift_d;
   logic [2:0]           bit_idx_q,  bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 txd_q,      txd_d;
`ifdef UART_TX_PARITY_EN
   logic                 par_q,      par_d;
`endif

   logic bit_end;
   logic last_stop;
   logic launch_ok;
   logic launch;

   // Bit-end, final-stop and launch decode; reset suppresses pops and the done pulse in its own cycle
   always_comb begin
      bit_end   = (cnt_q == '0);
      last_stop = (state_q == ST_STOP) && bit_end && (stop_idx_q == nstop_q);
      launch_ok = txen && !tx_fifo_empty && !reset;
      launch    = launch_ok && ((state_q == ST_IDLE) || last_stop);
   end

   // Next-state logic; txd_d is the line level for the next cycle so txd comes straight from a flop
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      nstop_d    = nstop_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      txd_d      = txd_q;
`ifdef UART_TX_PARITY_EN
      par_d      = par_q;
`endif
      if (launch) begin
         // Divisor and stop count are frozen here so register writes mid-frame wait for the next frame
         state_d    = ST_START;
         shift_d    = tx_fifo_rd_data;
         div_d      = div;
         nstop_d    = nstop;
         cnt_d      = div;
         bit_idx_d  = 3'd0;
         stop_idx_d = 1'b0;
         txd_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_d      = ^tx_fifo_rd_data;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               txd_d = 1'b1;
            end
            ST_START: begin
               if (bit_end) begin
                  state_d   = ST_DATA;
                  cnt_d     = div_q;
                  bit_idx_d = 3'd0;
                  txd_d     = shift_q[0];
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  cnt_d = div_q;
                  if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state_d = ST_PARITY;
                     txd_d   = par_q;
`else
                     state_d    = ST_STOP;
                     stop_idx_d = 1'b0;
                     txd_d      = 1'b1;
`endif
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                     shift_d   = shift_q >> 1;
                     txd_d     = shift_q[1];
                  end
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  state_d    = ST_STOP;
                  cnt_d      = div_q;
                  stop_idx_d = 1'b0;
                  txd_d      = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
`endif
            ST_STOP: begin
               if (last_stop) begin
                  // No launch this cycle (handled above), so the line goes idle
                  state_d = ST_IDLE;
                  txd_d   = 1'b1;
               end else if (bit_end) begin
                  stop_idx_d = 1'b1;
                  cnt_d      = div_q;
                  txd_d      = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               txd_d   = 1'b1;
            end
         endcase
      end
   end

   // State registers with synchronous reset; an in-flight frame is simply dropped
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         div_q      <= '0;
         nstop_q    <= 1'b0;
         shift_q    <= 8'h00;
         bit_idx_q  <= 3'd0;
         stop_idx_q <= 1'b0;
         txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         nstop_q    <= nstop_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign tx_fifo_rd_en = launch;
   assign frame_done    = last_stop && !reset;
   assign busy          = (state_q != ST_IDLE);
   assign txd           = txd_q;

endmodule

// File: tb/tb_uart_tx_phy.sv
// Directed bench for uart_tx_phy: FWFT FIFO model, per-cycle line checks against hand-derived frames.
// Inputs change and outputs are sampled just after the falling edge; FIFO pops on the rising edge.
// Honours UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_tx_phy;

   logic        clock = 1'b0;
   logic        reset;
   logic        txen;
   logic        nstop;
   logic [15:0] div;
   logic        tx_fifo_empty;
   logic [7:0]  tx_fifo_rd_data;
   logic        tx_fifo_rd_en;
   logic        txd;
   logic        busy;
   logic        frame_done;

   int n_cmp   = 0;
   int n_bad   = 0;
   int pops    = 0;
   int dones   = 0;
   int rd_viol = 0;

   logic [7:0] mem [0:63];
   int wp = 0;
   int rp = 0;

   always #5 clock = ~clock;

   assign tx_fifo_empty   = (wp == rp);
   assign tx_fifo_rd_data = mem[rp[5:0]];

   uart_tx_phy #(.DIV_WIDTH(16)) dut (
      .clock           (clock),
      .reset           (reset),
      .txen            (txen),
      .nstop           (nstop),
      .div             (div),
      .tx_fifo_empty   (tx_fifo_empty),
      .tx_fifo_rd_data (tx_fifo_rd_data),
      .tx_fifo_rd_en   (tx_fifo_rd_en),
      .txd             (txd),
      .busy            (busy),
      .frame_done      (frame_done)
   );

   // FIFO read side and event counters, sampled at the rising edge
   always @(posedge clock) begin
      if (tx_fifo_rd_en) begin
         pops++;
         if (wp == rp) rd_viol++;
         else rp <= rp + 1;
      end
      if (frame_done) dones++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      mem[wp[5:0]] = b;
      wp = wp + 1;
   endtask

   function automatic int n_bits(input int ns);
`ifdef UART_TX_PARITY_EN
      return 11 + ns;
`else
      return 10 + ns;
`endif
   endfunction

   function automatic int exp_bit(input logic [7:0] b, input int k);
      if (k == 0) return 0;
      if (k <= 8) return int'(b[k-1]);
`ifdef UART_TX_PARITY_EN
      if (k == 9) return int'(^b);
`endif
      return 1;
   endfunction

   // Waits (bounded) for the pop strobe; a launch from idle must show busy low in that cycle
   task automatic wait_pop(input string tag);
      int n = 0;
      #1;
      while (!tx_fifo_rd_en && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_pop"}, int'(tx_fifo_rd_en), 1);
      chk({tag, "_pop_busy"}, int'(busy), 0);
   endtask

   // Called in the pop cycle; checks every cycle of the frame that follows
   task automatic expect_frame(input logic [7:0] b, input int d, input int ns, input int last_pop,
                               input int off_at, input int div7_at, input string tag);
      int len;
      len = n_bits(ns) * (d + 1);
      for (int c = 1; c <= len; c++) begin
         tick();
         chk($sformatf("%s_txd_c%0d", tag, c), int'(txd), exp_bit(b, (c - 1) / (d + 1)));
         chk($sformatf("%s_busy_c%0d", tag, c), int'(busy), 1);
         chk($sformatf("%s_done_c%0d", tag, c), int'(frame_done), (c == len) ? 1 : 0);
         chk($sformatf("%s_rd_c%0d", tag, c), int'(tx_fifo_rd_en), (c == len) ? last_pop : 0);
         if (c == off_at) txen = 1'b0;
         if (c == div7_at) div = 16'd7;
      end
   endtask

   task automatic idle_chk(input string tag);
      tick();
      chk({tag, "_txd"}, int'(txd), 1);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(frame_done), 0);
   endtask

   initial begin
      reset = 1'b1;
      txen  = 1'b1;
      nstop = 1'b0;
      div   = 16'd3;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_txd", int'(txd), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(frame_done), 0);
      chk("rst_rd", int'(tx_fifo_rd_en), 0);

      // 8N1, 4-cycle bits
      push(8'hA5);
      wait_pop("a5");
      expect_frame(8'hA5, 3, 0, 0, -1, -1, "a5");
      idle_chk("a5_idle");

      // 1-cycle bits, two stop bits
      div   = 16'd0;
      nstop = 1'b1;
      push(8'h00);
      wait_pop("z0");
      expect_frame(8'h00, 0, 1, 0, -1, -1, "z0");
      idle_chk("z0_idle");

      // Gapless back-to-back frames
      div   = 16'd1;
      nstop = 1'b0;
      push(8'h55);
      push(8'h0F);
      wait_pop("b2b");
      expect_frame(8'h55, 1, 0, 1, -1, -1, "b55");
      expect_frame(8'h0F, 1, 0, 0, -1, -1, "b0f");
      idle_chk("b2b_idle");

      // txen gating, then drop txen during data bit 2
      div  = 16'd3;
      txen = 1'b0;
      push(8'h3C);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("off_rd_%0d", i), int'(tx_fifo_rd_en), 0);
         chk($sformatf("off_txd_%0d", i), int'(txd), 1);
      end
      txen = 1'b1;
      wait_pop("on");
      push(8'h99);
      expect_frame(8'h3C, 3, 0, 0, 14, -1, "x3c");
      idle_chk("x3c_idle");
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("off2_rd_%0d", i), int'(tx_fifo_rd_en), 0);
      end
      txen = 1'b1;
      wait_pop("x99");
      expect_frame(8'h99, 3, 0, 0, -1, -1, "x99");
      idle_chk("x99_idle");

      // Reset during data bit 3 abandons the frame
      push(8'hC3);
      wait_pop("rc3");
      for (int i = 0; i < 18; i++) tick();
      reset = 1'b1;
      tick();
      chk("mrst_txd", int'(txd), 1);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_done", int'(frame_done), 0);
      chk("mrst_rd", int'(tx_fifo_rd_en), 0);
      reset = 1'b0;
      push(8'h81);
      wait_pop("r81");
      expect_frame(8'h81, 3, 0, 0, -1, -1, "r81");
      idle_chk("r81_idle");

      // div changed mid-frame only affects the next frame
      push(8'h07);
      push(8'h5A);
      wait_pop("dv");
      expect_frame(8'h07, 3, 0, 1, -1, 10, "d07");
      expect_frame(8'h5A, 7, 0, 0, -1, -1, "d5a");
      idle_chk("d5a_idle");

      chk("total_pops", pops, 10);
      chk("total_dones", dones, 9);
      chk("rd_while_empty", rd_viol, 0);
      chk("fifo_drained", rp, wp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
